// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 16-bit Galois LFSR word stream (poly taps 0x002D).
// Define PRBS_CHK_BITERR_EN to weight each mismatching word by its bit-error count.
module prbs_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  input  logic [15:0]      data_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      expected
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

  state_t           state, state_nxt;
  logic [15:0]      prev, prev_nxt, expected_nxt;
  logic [3:0]       match_cnt, match_nxt;
  logic [3:0]       miss_cnt, miss_nxt;
  logic [ERR_W-1:0] err_nxt, err_base;
  logic             pulse_nxt;
  logic             sync_match, lock_match;
  logic [4:0]       mc_inc, ms_inc;
  logic [4:0]       weight;

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h002D : 16'h0000);
  endfunction

  // Sum is formed ERR_W+5 bits wide so a 16-bit weight can never wrap before the clamp.
  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] base,
                                               input logic [4:0] w);
    logic [ERR_W+4:0] sum;
    sum = {5'b0, base} + {{ERR_W{1'b0}}, w};
    if (sum > {5'b0, {ERR_W{1'b1}}}) return {ERR_W{1'b1}};
    return sum[ERR_W-1:0];
  endfunction

`ifdef PRBS_CHK_BITERR_EN
  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) cnt = cnt + {4'd0, v[i]};
    return cnt;
  endfunction

  assign weight = popcount(data_in ^ expected);
`else
  assign weight = 5'd1;
`endif

  assign sync_match = (data_in == step(prev)) && (data_in != 16'h0000);
  assign lock_match = (data_in == expected);
  assign mc_inc     = {1'b0, match_cnt} + 5'd1;
  assign ms_inc     = {1'b0, miss_cnt} + 5'd1;
  assign err_base   = err_clr ? {ERR_W{1'b0}} : err_count;

  always_ff @(posedge clk) begin
    if (!rst) state <= HUNT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (data_valid) begin
      case (state)
        HUNT:    state_nxt = SYNC;
        SYNC:    if (sync_match && mc_inc == 5'(LOCK_CNT)) state_nxt = LOCK;
        LOCK:    if (!lock_match && ms_inc == 5'(LOSS_CNT)) state_nxt = HUNT;
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    prev_nxt     = prev;
    match_nxt    = match_cnt;
    miss_nxt     = miss_cnt;
    expected_nxt = expected;
    err_nxt      = err_base;
    pulse_nxt    = 1'b0;
    if (data_valid) begin
      case (state)
        HUNT: begin
          prev_nxt  = data_in;
          match_nxt = 4'd0;
        end
        SYNC: begin
          prev_nxt = data_in;
          if (sync_match) begin
            match_nxt = mc_inc[3:0];
            if (mc_inc == 5'(LOCK_CNT)) begin
              expected_nxt = step(data_in);
              miss_nxt     = 4'd0;
            end
          end else begin
            match_nxt = 4'd0;
          end
        end
        LOCK: begin
          // Flywheel: the expected word advances whether or not this word matched.
          expected_nxt = step(expected);
          if (lock_match) begin
            miss_nxt = 4'd0;
          end else begin
            pulse_nxt = 1'b1;
            err_nxt   = sat_add(err_base, weight);
            miss_nxt  = (ms_inc == 5'(LOSS_CNT)) ? 4'd0 : ms_inc[3:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev      <= 16'h0000;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      expected  <= 16'h0000;
      err_count <= {ERR_W{1'b0}};
      err_pulse <= 1'b0;
      locked    <= 1'b0;
    end else begin
      prev      <= prev_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      expected  <= expected_nxt;
      err_count <= err_nxt;
      err_pulse <= pulse_nxt;
      locked    <= (state_nxt == LOCK);
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a default instance and a narrow-counter / long-loss instance,
// both compared every cycle against a word-level reference model.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst, data_valid, err_clr;
  logic [15:0] data_in;
  logic        locked_a, pulse_a, locked_b, pulse_b;
  logic [15:0] errc_a, exp_a, exp_b;
  logic [1:0]  errc_b;

  int checks = 0;
  int failures = 0;

  // Reference model state, index 0 = default instance, 1 = ERR_W=2 / LOSS_CNT=15.
  int          st[2];
  int          mc[2];
  int          ms[2];
  int          ec[2];
  bit          ep[2];
  logic [15:0] pv[2];
  logic [15:0] ex[2];
  int          loss_n[2] = '{3, 15};
  int          emax[2]   = '{65535, 3};
  logic [15:0] seqw;

  always #5 clk = ~clk;

  prbs_checker u_dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in), .err_clr(err_clr),
    .locked(locked_a), .err_pulse(pulse_a), .err_count(errc_a), .expected(exp_a)
  );

  prbs_checker #(.LOCK_CNT(4), .LOSS_CNT(15), .ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in), .err_clr(err_clr),
    .locked(locked_b), .err_pulse(pulse_b), .err_count(errc_b), .expected(exp_b)
  );

  function automatic logic [15:0] lfsr(input logic [15:0] s);
    int v;
    v = (int'(s) * 2) % 65536;
    if (s >= 16'h8000) v = v ^ 45;
    return 16'(v);
  endfunction

  function automatic int err_weight(input logic [15:0] x);
    int w;
    w = $countones(x);
`ifndef PRBS_CHK_BITERR_EN
    w = 1;
`endif
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      st[m] = 0; mc[m] = 0; ms[m] = 0; ec[m] = 0; ep[m] = 0;
      pv[m] = 16'h0000; ex[m] = 16'h0000;
    end
  endtask

  task automatic model_clock(input bit v, input logic [15:0] d, input bit clr);
    for (int m = 0; m < 2; m++) begin
      int base;
      base  = clr ? 0 : ec[m];
      ep[m] = 0;
      ec[m] = base;
      if (v) begin
        if (st[m] == 0) begin
          pv[m] = d; mc[m] = 0; st[m] = 1;
        end else if (st[m] == 1) begin
          if (d == lfsr(pv[m]) && d != 16'h0000) begin
            mc[m]++;
            if (mc[m] == 4) begin
              st[m] = 2; ex[m] = lfsr(d); ms[m] = 0;
            end
          end else begin
            mc[m] = 0;
          end
          pv[m] = d;
        end else begin
          if (d == ex[m]) begin
            ms[m] = 0;
          end else begin
            ep[m] = 1;
            ec[m] = base + err_weight(d ^ ex[m]);
            if (ec[m] > emax[m]) ec[m] = emax[m];
            ms[m]++;
            if (ms[m] == loss_n[m]) begin
              st[m] = 0; ms[m] = 0;
            end
          end
          ex[m] = lfsr(ex[m]);
        end
      end
    end
  endtask

  task automatic compare_all();
    check("locked_a", locked_a, st[0] == 2);
    check("pulse_a", pulse_a, ep[0]);
    check("errc_a", errc_a, ec[0]);
    check("expected_a", exp_a, ex[0]);
    check("locked_b", locked_b, st[1] == 2);
    check("pulse_b", pulse_b, ep[1]);
    check("errc_b", errc_b, ec[1]);
    check("expected_b", exp_b, ex[1]);
  endtask

  task automatic cyc(input bit v, input logic [15:0] d, input bit clr);
    @(negedge clk);
    rst = 1'b1; data_valid = v; data_in = d; err_clr = clr;
    @(posedge clk);
    model_clock(v, d, clr);
    #1 compare_all();
  endtask

  // Inputs are randomised during reset to show reset overrides them.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; data_valid = 1'($urandom); data_in = 16'($urandom); err_clr = 1'($urandom);
    @(posedge clk);
    model_reset();
    #1 compare_all();
  endtask

  task automatic good(input int n);
    repeat (n) begin
      cyc(1'b1, seqw, 1'b0);
      seqw = lfsr(seqw);
    end
  endtask

  task automatic bad(input logic [15:0] mask);
    cyc(1'b1, seqw ^ mask, 1'b0);
    seqw = lfsr(seqw);
  endtask

  initial begin
    rst = 1'b0; data_valid = 1'b0; data_in = 16'h0000; err_clr = 1'b0;
    do_reset();
    check("rst_locked", locked_a, 1'b0);
    check("rst_errc", errc_a, 0);
    check("rst_expected", exp_a, 16'h0000);

    seqw = 16'hACE1;
    good(4);
    check("prelock", locked_a, 1'b0);
    good(1);
    check("lock5", locked_a, 1'b1);
    check("lock_expected", exp_a, seqw);
    check("lock_errc", errc_a, 0);

    good(3);
    bad(16'h0001);
    check("single_pulse", pulse_a, 1'b1);
    check("single_errc", errc_a, 1);
    good(1);
    check("single_pulse_off", pulse_a, 1'b0);
    good(4);
    check("single_still_locked", locked_a, 1'b1);
    check("single_errc_hold", errc_a, 1);

    bad(16'h0100);
    bad(16'h0100);
    check("loss_2_locked", locked_a, 1'b1);
    bad(16'h0100);
    check("loss_3_unlocked", locked_a, 1'b0);
    check("loss_errc", errc_a, 4);
    good(4);
    check("relock_4", locked_a, 1'b0);
    good(1);
    check("relock_5", locked_a, 1'b1);

    repeat (20) begin
      if ($urandom_range(0, 1) == 0) cyc(1'b0, 16'($urandom), 1'b0);
      else good(1);
    end
    check("gaps_locked", locked_a, 1'b1);
    check("gaps_errc", errc_a, 4);

    do_reset();
    seqw = 16'($urandom_range(1, 65535));
    good(5);
    repeat (7) begin
      bad(16'h0001);
      good(1);
    end
    check("clr_pre", errc_a, 7);
    cyc(1'b1, seqw ^ 16'h0001, 1'b1);
    seqw = lfsr(seqw);
    check("clr_with_err", errc_a, 1);
    check("clr_locked", locked_a, 1'b1);

    do_reset();
    good(5);
    repeat (5) bad(16'h0003);
    check("sat_errc", errc_b, 2'd3);
    check("sat_locked", locked_b, 1'b1);

    do_reset();
    repeat (20) cyc(1'b1, 16'h0000, 1'b0);
    check("zero_locked", locked_a, 1'b0);
    check("zero_errc", errc_a, 0);

    do_reset();
    good(6);
    bad(16'h0040);
    do_reset();
    check("midrst_locked", locked_a, 1'b0);
    check("midrst_pulse", pulse_a, 1'b0);
    check("midrst_errc", errc_a, 0);
    check("midrst_expected", exp_a, 16'h0000);

    repeat (3000) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 1) do_reset();
      else if (r < 3) begin
        seqw = 16'($urandom_range(1, 65535));
        good(1);
      end
      else if (r < 15) cyc(1'b0, 16'($urandom), 1'b0);
      else if (r < 22) bad(16'($urandom_range(1, 65535)));
      else if (r < 25) begin
        cyc(1'b1, seqw ^ 16'($urandom_range(0, 3)), 1'b1);
        seqw = lfsr(seqw);
      end
      else good(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
